// File: rtl/uart_cmd_parser_pkg.sv
// rtl/uart_cmd_parser_pkg.sv - command codes, error/mode encodings and parser states
package uart_cmd_parser_pkg;

    typedef enum logic [7:0] {
        CMD_DATA   = 8'h01,
        CMD_CTRL   = 8'h02,
        CMD_FREQ   = 8'h03,
        CMD_PERIOD = 8'h04,
        CMD_REPEAT = 8'h05
    } cmd_e;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'b00,
        ERR_UNKNOWN_CMD = 2'b01,
        ERR_BAD_CH      = 2'b10,
        ERR_TIMEOUT     = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        MODE_ONE_SHOT = 2'b00,
        MODE_CONTINUE = 2'b01,
        MODE_REPEAT   = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CH      = 2'b01,
        ST_PAYLOAD = 2'b10
    } state_e;

    // Index of the final payload byte (the byte that triggers the commit).
    function automatic logic [7:0] payload_last(input cmd_e op, input int data_bytes);
        case (op)
            CMD_DATA, CMD_FREQ: payload_last = 8'(data_bytes - 1);
            CMD_PERIOD:         payload_last = 8'd1;
            default:            payload_last = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/cmd_timeout.sv
// rtl/cmd_timeout.sv - inter-byte timeout counter with clear/enable and expire tick
module cmd_timeout #(
    parameter int LIMIT = 20000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Fires on the edge where the idle count reaches LIMIT-1; a tick always wins.
    assign expire_o = en_i && !clr_i && (cnt_q == CW'(LIMIT - 2));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || !en_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART byte-stream command frame decoder emitting write strobes
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int DATA_BIT       = 32,
    parameter int OUTPUT_NUM     = 16,
    parameter int CH_W           = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [7:0]          data_i,
    input  logic                rx_done_tick_i,
    output logic [CH_W-1:0]     ch_o,
    output logic [DATA_BIT-1:0] pattern_o,
    output logic                data_we_o,
    output logic                ctrl_we_o,
    output logic [1:0]          mode_o,
    output logic                en_o,
    output logic                freq_we_o,
    output logic                period_we_o,
    output logic [7:0]          slow_period_o,
    output logic [7:0]          fast_period_o,
    output logic                repeat_we_o,
    output logic [7:0]          repeat_o,
    output logic                busy_o,
    output logic                err_tick_o,
    output logic [1:0]          err_code_o
);

    localparam int         DATA_BYTES = DATA_BIT / 8;
    localparam int         SR_W       = DATA_BIT - 8;
    localparam logic [8:0] CH_LIMIT   = 9'(OUTPUT_NUM);

    state_e                state_q, state_d;
    cmd_e                  op_q, op_d;
    logic                  drop_q, drop_d;
    logic [CH_W-1:0]       chan_q, chan_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [SR_W-1:0]       sr_q, sr_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [DATA_BIT-1:0]   pattern_q, pattern_d;
    mode_e                 mode_q, mode_d;
    logic                  en_q, en_d;
    logic [7:0]            slow_q, slow_d, fast_q, fast_d, repeat_q, repeat_d;
    err_code_e             err_code_q, err_code_d;
    logic                  data_we_q, data_we_d, ctrl_we_q, ctrl_we_d, freq_we_q, freq_we_d;
    logic                  period_we_q, period_we_d, repeat_we_q, repeat_we_d;
    logic                  err_tick_q, err_tick_d;
    logic                  busy, expire;

    assign busy = (state_q != ST_IDLE);

    cmd_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (rx_done_tick_i),
        .en_i     (busy),
        .expire_o (expire)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        drop_d      = drop_q;
        chan_d      = chan_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        ch_d        = ch_q;
        pattern_d   = pattern_q;
        mode_d      = mode_q;
        en_d        = en_q;
        slow_d      = slow_q;
        fast_d      = fast_q;
        repeat_d    = repeat_q;
        err_code_d  = err_code_q;
        data_we_d   = 1'b0;
        ctrl_we_d   = 1'b0;
        freq_we_d   = 1'b0;
        period_we_d = 1'b0;
        repeat_we_d = 1'b0;
        err_tick_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_done_tick_i) begin
                    drop_d = 1'b0;
                    cnt_d  = 8'd0;
                    case (data_i)
                        CMD_DATA, CMD_CTRL, CMD_REPEAT: begin
                            op_d    = cmd_e'(data_i);
                            state_d = ST_CH;
                        end
                        CMD_FREQ, CMD_PERIOD: begin
                            op_d    = cmd_e'(data_i);
                            state_d = ST_PAYLOAD;
                        end
                        default: begin
                            err_tick_d = 1'b1;
                            err_code_d = ERR_UNKNOWN_CMD;
                        end
                    endcase
                end
            end
            ST_CH: begin
                if (rx_done_tick_i) begin
                    chan_d  = data_i[CH_W-1:0];
                    drop_d  = ({1'b0, data_i} >= CH_LIMIT);
                    cnt_d   = 8'd0;
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (rx_done_tick_i) begin
                    sr_d  = {data_i, sr_q[SR_W-1:8]};
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == payload_last(op_q, DATA_BYTES)) begin
                        state_d = ST_IDLE;
                        if (drop_q) begin
                            err_tick_d = 1'b1;
                            err_code_d = ERR_BAD_CH;
                        end else begin
                            case (op_q)
                                CMD_DATA: begin
                                    ch_d      = chan_q;
                                    pattern_d = {data_i, sr_q};
                                    data_we_d = 1'b1;
                                end
                                CMD_CTRL: begin
                                    ch_d      = chan_q;
                                    mode_d    = mode_e'(data_i[2:1]);
                                    en_d      = data_i[0];
                                    ctrl_we_d = 1'b1;
                                end
                                CMD_FREQ: begin
                                    pattern_d = {data_i, sr_q};
                                    freq_we_d = 1'b1;
                                end
                                CMD_PERIOD: begin
                                    slow_d      = sr_q[SR_W-1 -: 8];
                                    fast_d      = data_i;
                                    period_we_d = 1'b1;
                                end
                                default: begin
                                    ch_d        = chan_q;
                                    repeat_d    = data_i;
                                    repeat_we_d = 1'b1;
                                end
                            endcase
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Expiry only occurs without a tick, so it never collides with a commit.
        if (expire) begin
            state_d    = ST_IDLE;
            err_tick_d = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            op_q        <= CMD_DATA;
            drop_q      <= 1'b0;
            chan_q      <= '0;
            cnt_q       <= 8'd0;
            sr_q        <= '0;
            ch_q        <= '0;
            pattern_q   <= '0;
            mode_q      <= MODE_ONE_SHOT;
            en_q        <= 1'b0;
            slow_q      <= 8'd0;
            fast_q      <= 8'd0;
            repeat_q    <= 8'd0;
            err_code_q  <= ERR_NONE;
            data_we_q   <= 1'b0;
            ctrl_we_q   <= 1'b0;
            freq_we_q   <= 1'b0;
            period_we_q <= 1'b0;
            repeat_we_q <= 1'b0;
            err_tick_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            drop_q      <= drop_d;
            chan_q      <= chan_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            ch_q        <= ch_d;
            pattern_q   <= pattern_d;
            mode_q      <= mode_d;
            en_q        <= en_d;
            slow_q      <= slow_d;
            fast_q      <= fast_d;
            repeat_q    <= repeat_d;
            err_code_q  <= err_code_d;
            data_we_q   <= data_we_d;
            ctrl_we_q   <= ctrl_we_d;
            freq_we_q   <= freq_we_d;
            period_we_q <= period_we_d;
            repeat_we_q <= repeat_we_d;
            err_tick_q  <= err_tick_d;
        end
    end

    assign ch_o          = ch_q;
    assign pattern_o     = pattern_q;
    assign data_we_o     = data_we_q;
    assign ctrl_we_o     = ctrl_we_q;
    assign mode_o        = mode_q;
    assign en_o          = en_q;
    assign freq_we_o     = freq_we_q;
    assign period_we_o   = period_we_q;
    assign slow_period_o = slow_q;
    assign fast_period_o = fast_q;
    assign repeat_we_o   = repeat_we_q;
    assign repeat_o      = repeat_q;
    assign busy_o        = busy;
    assign err_tick_o    = err_tick_q;
    assign err_code_o    = err_code_q;

endmodule
